axis_mac_array: RTL

Parametrised multi-lane AXI-Stream multiply-accumulate engine for the CNN datapath. It replaces the single-channel stream MAC example IP. Each input beat carries LANES signed activation/weight pairs. Each lane accumulates a dot product over a configurable beat count or until TLAST, then emits one rescaled, optionally ReLU-clamped, saturated result per lane on the master stream. It sits between the line-buffer/weight-fetch stage and the pooling stage.

---
 rtl/axis_mac_array.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/axis_mac_array.sv
// Multi-lane AXI-Stream multiply-accumulate engine: per-lane dot products over cfg_len beats
// or until TLAST, then one shifted, optionally ReLU-clamped, saturated result per lane.
module axis_mac_array #(
   parameter int LANES  = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int OUT_W  = 16,
   parameter int LEN_W  = 10
) (
   input  logic                        ACLK,
   input  logic                        ARESETN,
   input  logic [LANES*2*DATA_W-1:0]   S_AXIS_TDATA,
   input  logic                        S_AXIS_TVALID,
   input  logic                        S_AXIS_TLAST,
   output logic                        S_AXIS_TREADY,
   output logic [LANES*OUT_W-1:0]      M_AXIS_TDATA,
   output logic                        M_AXIS_TVALID,
   output logic                        M_AXIS_TLAST,
   input  logic                        M_AXIS_TREADY,
   input  logic [LEN_W-1:0]            cfg_len,
   input  logic [4:0]                  cfg_shift,
   input  logic                        cfg_relu,
   input  logic                        clear_err,
   output logic                        busy,
   output logic                        err_len,
   output logic                        sat_flag
);

   localparam int PW = 2 * DATA_W;
   localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

   state_t state, state_next;

   logic                     rdy_q;
   logic [LEN_W-1:0]         len_q;
   logic [LEN_W-1:0]         cnt_q;
   logic [4:0]               shift_q;
   logic                     relu_q;
   logic signed [ACC_W-1:0]  acc_q    [LANES];
   logic signed [ACC_W-1:0]  acc_next [LANES];
   logic [LANES*OUT_W-1:0]   res_data;
   logic [LANES-1:0]         clip;

   logic                     accept;
   logic                     out_fire;
   logic                     terminal;
   logic                     short_pkt;
   logic [LEN_W-1:0]         len_eff;
   logic [LEN_W-1:0]         beat_num;
   logic [4:0]               shift_eff;
   logic                     relu_eff;

   assign S_AXIS_TREADY = rdy_q & (state != OUTPUT);
   assign M_AXIS_TVALID = (state == OUTPUT);
   assign busy          = (state != IDLE);
   assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;
   assign out_fire      = M_AXIS_TVALID & M_AXIS_TREADY;

   // The first beat of a product sees the live config; later beats use the shadow copies.
   assign len_eff   = (state == IDLE) ? cfg_len   : len_q;
   assign shift_eff = (state == IDLE) ? cfg_shift : shift_q;
   assign relu_eff  = (state == IDLE) ? cfg_relu  : relu_q;
   assign beat_num  = (state == IDLE) ? LEN_W'(1) : cnt_q + LEN_W'(1);

   assign terminal  = S_AXIS_TLAST | ((len_eff != '0) & (beat_num == len_eff));
   assign short_pkt = S_AXIS_TLAST & (len_eff != '0) & (beat_num < len_eff);

   // Per-lane product, accumulate, and the result the beat would produce if it were terminal.
   always_comb begin : datapath
      logic signed [PW-1:0]    a_ext;
      logic signed [PW-1:0]    w_ext;
      logic signed [PW-1:0]    prod;
      logic signed [ACC_W-1:0] prod_ext;
      logic signed [ACC_W-1:0] shifted;
      acc_next = acc_q;
      res_data = '0;
      clip     = '0;
      for (int i = 0; i < LANES; i++) begin
         a_ext    = {{DATA_W{S_AXIS_TDATA[i*PW+DATA_W-1]}}, S_AXIS_TDATA[i*PW +: DATA_W]};
         w_ext    = {{DATA_W{S_AXIS_TDATA[i*PW+PW-1]}}, S_AXIS_TDATA[i*PW+DATA_W +: DATA_W]};
         prod     = a_ext * w_ext;
         prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
         acc_next[i] = (state == IDLE) ? prod_ext : acc_q[i] + prod_ext;
         shifted  = acc_next[i] >>> shift_eff;
         if (relu_eff && shifted[ACC_W-1]) begin
            shifted = '0;
         end
         if (shifted > OUT_MAX) begin
            res_data[i*OUT_W +: OUT_W] = OUT_MAX[OUT_W-1:0];
            clip[i] = 1'b1;
         end else if (shifted < OUT_MIN) begin
            res_data[i*OUT_W +: OUT_W] = OUT_MIN[OUT_W-1:0];
            clip[i] = 1'b1;
         end else begin
            res_data[i*OUT_W +: OUT_W] = shifted[OUT_W-1:0];
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = terminal ? OUTPUT : ACCUM;
            end
         end
         ACCUM: begin
            if (accept && terminal) begin
               state_next = OUTPUT;
            end
         end
         OUTPUT: begin
            if (out_fire) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state        <= IDLE;
         rdy_q        <= 1'b0;
         len_q        <= '0;
         cnt_q        <= '0;
         shift_q      <= '0;
         relu_q       <= 1'b0;
         M_AXIS_TDATA <= '0;
         M_AXIS_TLAST <= 1'b0;
      end else begin
         state <= state_next;
         rdy_q <= 1'b1;
         if (accept) begin
            cnt_q <= beat_num;
            if (state == IDLE) begin
               len_q   <= cfg_len;
               shift_q <= cfg_shift;
               relu_q  <= cfg_relu;
            end
            if (terminal) begin
               M_AXIS_TDATA <= res_data;
               M_AXIS_TLAST <= S_AXIS_TLAST;
            end
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < LANES; i++) begin
            acc_q[i] <= '0;
         end
      end else if (accept) begin
         for (int i = 0; i < LANES; i++) begin
            acc_q[i] <= acc_next[i];
         end
      end
   end

   // Sticky flags: a new set in the same cycle as clear_err takes priority.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         err_len  <= 1'b0;
         sat_flag <= 1'b0;
      end else begin
         if (accept && short_pkt) begin
            err_len <= 1'b1;
         end else if (clear_err) begin
            err_len <= 1'b0;
         end
         if (accept && terminal && (|clip)) begin
            sat_flag <= 1'b1;
         end else if (clear_err) begin
            sat_flag <= 1'b0;
         end
      end
   end

endmodule
